carwash_timers: RTL
===================

CARWASH_TIMERS -- requirements
Module: carwash_timers

Interface
REQ-001 Parameter PRESCALE, default 10: clk cycles per timer tick; legal range 1..65535.
REQ-002 Parameter TW, default 8: width of time-limit inputs and tick counters.
REQ-003 clk  input  1  the one clock; all state updates on posedge clk.
REQ-004 CLR_N  input  1  reset, asynchronous and active-low.
REQ-005 CLRT1  input  1  clear/restart spray timer; active high; driven by carwash_fsm.
REQ-006 CLRT2  input  1  clear/restart rinse timer; active high; driven by carwash_fsm.
REQ-007 HOLD  input  1  freeze both timers (door-open interlock); active high.
REQ-008 SPRAY_TIME  input  TW  spray limit in ticks; sampled only while CLRT1=1.
REQ-009 RINSE_TIME  input  TW  rinse limit in ticks; sampled only while CLRT2=1.
REQ-010 T1DONE  output  1  spray time expired; active high; consumed by carwash_fsm.
REQ-011 T2DONE  output  1  rinse time expired; active high; consumed by carwash_fsm.

Function
REQ-012 Each timer SHALL hold prescale count pre (16 bit), tick count cnt (TW bit), latched limit lim (TW bit) and registered DONE.
REQ-013 Clear: any cycle CLRTx=1 SHALL set pre=0, cnt=0, DONEx=0 and lim=current SPRAY_TIME/RINSE_TIME at that edge.
REQ-014 Run: CLRTx=0, HOLD=0, DONEx=0: pre increments; at pre==PRESCALE-1, pre wraps to 0 and cnt increments.
REQ-015 DONEx SHALL be set at the edge where cnt becomes equal to lim; latency with limit L>=1 is exactly PRESCALE*L counting cycles after CLRTx deasserts.
REQ-016 Limit 0: DONEx SHALL be set at the first edge with CLRTx=0, HOLD=0 (one-cycle latency).
REQ-017 DONEx SHALL stay high (level, not pulse) until the next cycle with CLRTx=1; once DONE, pre and cnt freeze (no wrap of cnt).
REQ-018 HOLD=1 with CLRTx=0 SHALL freeze pre, cnt, DONEx; counting resumes from same values when HOLD drops.
REQ-019 Priority per timer: reset > CLRTx > HOLD > count.
REQ-020 CLRT1 and CLRT2 SHALL act independently; both asserted together clears both.
REQ-021 CLRTx asserted mid-count or while DONE SHALL restart that timer only, with a freshly sampled limit.
REQ-022 Changes to SPRAY_TIME/RINSE_TIME while CLRTx=0 SHALL have no effect on the running timer.
REQ-023 Outputs SHALL be driven directly from flops (no combinational path from inputs to T1DONE/T2DONE).

Reset
REQ-024 CLR_N=0 SHALL asynchronously force pre=0, cnt=0, lim=0, T1DONE=0, T2DONE=0.
REQ-025 After CLR_N rises, timers SHALL remain idle (count not started) until their first CLRTx pulse; an idle timer with lim=0 SHALL NOT assert DONE until a CLRTx pulse has occurred (armed flag cleared by reset, set by CLRTx).
REQ-026 Reset asserted mid-count SHALL discard all progress; no DONE glitch on deassertion.

Structure
REQ-027 Shared package carwash_pkg SHALL hold the TW default and the per-timer state enum (T_IDLE, T_RUN, T_DONE).
REQ-028 One sub-module carwash_timer (single prescaler+counter+limit+DONE) SHALL be instantiated twice; top adds no logic beyond wiring and HOLD fan-out.

Verification
REQ-029 PRESCALE=10, SPRAY_TIME=3, CLRT1 high 1 cycle then low -> T1DONE rises exactly 30 cycles after CLRT1 falls, stays high 20+ cycles.
REQ-030 PRESCALE=10, RINSE_TIME=2, HOLD high 7 cycles at cycle 5 of count -> T2DONE rises at 27 cycles after CLRT2 falls.
REQ-031 SPRAY_TIME=5, CLRT1 re-pulsed at cycle 25 with SPRAY_TIME=1 -> T1DONE rises 10 cycles after second pulse, not at 50.
REQ-032 SPRAY_TIME=0, CLRT1 pulse -> T1DONE high one cycle after CLRT1 falls; after reset only (no pulse) -> T1DONE stays 0.
REQ-033 CLR_N pulsed low (asynchronous, mid-cycle) during count with T2DONE pending -> both DONE 0 immediately, no assertion for 100 cycles without CLRTx.
REQ-034 Closed loop with carwash_fsm: TOKEN, START sequence -> observed S2 spray 30 cycles, S3 soap per RINSE_TIME, S4 spray per SPRAY_TIME, return to S0.

Source files
------------

// File: rtl/carwash_pkg.sv
// ---------------------------------------------------------------------------
// carwash_pkg
// Items shared by the carwash timer block:
//   TW_DEFAULT    - default width of the time limits and tick counters
//   timer_state_e - per-timer state (idle / running / expired)
// ---------------------------------------------------------------------------
package carwash_pkg;

   localparam int TW_DEFAULT = 8;

   // T_IDLE : not armed since reset; never raises DONE on its own
   // T_RUN  : armed by a clear pulse, counting (or frozen by HOLD)
   // T_DONE : limit reached; counters frozen, DONE held high
   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_RUN  = 2'd1,
      T_DONE = 2'd2
   } timer_state_e;

endpackage : carwash_pkg

// File: rtl/carwash_timers_if.sv
// ---------------------------------------------------------------------------
// carwash_timers_if
// Control/status bundle between the carwash controller and the timer block.
//   CLRT1, CLRT2           - clear/restart spray / rinse timer (active high)
//   HOLD                   - freeze both timers (door-open interlock)
//   SPRAY_TIME, RINSE_TIME - limits in ticks, sampled while CLRTx is high
//   T1DONE, T2DONE         - timer expired flags (level)
// master: controller side; slave: timer block side.
// ---------------------------------------------------------------------------
interface carwash_timers_if #(
   parameter int TW = carwash_pkg::TW_DEFAULT
);
   logic          CLRT1;
   logic          CLRT2;
   logic          HOLD;
   logic [TW-1:0] SPRAY_TIME;
   logic [TW-1:0] RINSE_TIME;
   logic          T1DONE;
   logic          T2DONE;

   modport master (
      output CLRT1, CLRT2, HOLD, SPRAY_TIME, RINSE_TIME,
      input  T1DONE, T2DONE
   );

   modport slave (
      input  CLRT1, CLRT2, HOLD, SPRAY_TIME, RINSE_TIME,
      output T1DONE, T2DONE
   );
endinterface : carwash_timers_if

// File: rtl/carwash_timer.sv
// ---------------------------------------------------------------------------
// carwash_timer
// One prescaled tick timer with latched limit and registered DONE flag.
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   clr_i   - clear/restart; samples limit_i, arms the timer
//   hold_i  - freeze prescaler, tick counter and DONE
//   limit_i - limit in ticks (PRESCALE clk cycles per tick)
//   done_o  - high from the edge the tick count reaches the limit until
//             the next clear
// ---------------------------------------------------------------------------
module carwash_timer
   import carwash_pkg::*;
#(
   parameter int PRESCALE = 10,
   parameter int TW       = TW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          hold_i,
   input  logic [TW-1:0] limit_i,
   output logic          done_o
);

   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

   timer_state_e  state_q, state_d;
   logic [15:0]   pre_q, pre_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] lim_q, lim_d;
   logic          done_q, done_d;
   logic [TW-1:0] cnt_inc;

   assign cnt_inc = cnt_q + TW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= T_IDLE;
         pre_q   <= '0;
         cnt_q   <= '0;
         lim_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         lim_q   <= lim_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      cnt_d   = cnt_q;
      lim_d   = lim_q;
      done_d  = done_q;

      if (clr_i) begin
         // Clear wins over HOLD: restart from zero with a fresh limit.
         state_d = T_RUN;
         pre_d   = '0;
         cnt_d   = '0;
         lim_d   = limit_i;
         done_d  = 1'b0;
      end else if (!hold_i) begin
         case (state_q)
            T_RUN: begin
               if (lim_q == '0) begin
                  // Zero limit expires on the first free-running edge.
                  state_d = T_DONE;
                  done_d  = 1'b1;
               end else if (pre_q == PRE_LAST) begin
                  pre_d = '0;
                  cnt_d = cnt_inc;
                  // DONE is raised on the same edge the count reaches the
                  // limit, so latency is exactly PRESCALE*limit cycles.
                  if (cnt_inc == lim_q) begin
                     state_d = T_DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  pre_d = pre_q + 16'd1;
               end
            end
            // Idle and expired timers stay frozen until the next clear.
            default: ;
         endcase
      end
   end

   assign done_o = done_q;

endmodule : carwash_timer

// File: rtl/carwash_timers.sv
// ---------------------------------------------------------------------------
// carwash_timers
// Spray (T1) and rinse (T2) timers for the carwash controller.
//   clk   - clock
//   CLR_N - asynchronous active-low reset
//   bus   - slave side of carwash_timers_if (CLRT1/2, HOLD, limits, DONEs)
// Two identical carwash_timer instances; HOLD fans out to both.
// ---------------------------------------------------------------------------
module carwash_timers
   import carwash_pkg::*;
#(
   parameter int PRESCALE = 10,
   parameter int TW       = TW_DEFAULT
) (
   input  logic             clk,
   input  logic             CLR_N,
   carwash_timers_if.slave  bus
);

   logic [1:0]    clr_w;
   logic [1:0]    done_w;
   logic [TW-1:0] limit_w [2];

   assign clr_w[0]   = bus.CLRT1;
   assign clr_w[1]   = bus.CLRT2;
   assign limit_w[0] = bus.SPRAY_TIME;
   assign limit_w[1] = bus.RINSE_TIME;

   for (genvar gi = 0; gi < 2; gi++) begin : g_timer
      carwash_timer #(
         .PRESCALE (PRESCALE),
         .TW       (TW)
      ) u_timer (
         .clk     (clk),
         .rst_n   (CLR_N),
         .clr_i   (clr_w[gi]),
         .hold_i  (bus.HOLD),
         .limit_i (limit_w[gi]),
         .done_o  (done_w[gi])
      );
   end

   assign bus.T1DONE = done_w[0];
   assign bus.T2DONE = done_w[1];

endmodule : carwash_timers
